// File: rtl/pri_irq_pkg.sv
// Shared definitions for the priority interrupt controller.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   clog2()              : index-width helper used to derive W from N.
package pri_irq_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Minimum of 1 bit so a degenerate channel count still yields a legal vector.
  function automatic int unsigned clog2(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pri_rotate_enc.sv
// Generalised (rotatable) priority encoder, purely combinational.
//   eligible : N request bits to arbitrate between
//   rr_ptr   : rotation point; used only in round-robin mode
//   mode     : MODE_FIXED = highest index wins, MODE_RR = search from rr_ptr-1 downwards
//   idx      : winning channel index (0 when none)
//   any      : at least one eligible bit is set
module pri_rotate_enc
  import pri_irq_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] rr_ptr,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         any
);

  int start;
  int cand;

  // Search order is start-1, start-2, ... wrapping, ending at start. Walking from the
  // lowest-priority slot upwards and letting later hits overwrite keeps it latch-free.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    start = (mode == MODE_RR) ? int'(rr_ptr) % int'(N) : 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = (start + int'(N) - 1 - k) % int'(N);
      if (eligible[cand[W-1:0]]) begin
        idx = cand[W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_irq_ctrl.sv
// Registered N-input priority encoder / interrupt controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : raw request lines
//   edge_sel   : per channel 1 = rising-edge capture, 0 = level capture
//   mask       : per channel grant enable
//   mode       : MODE_FIXED or MODE_RR
//   ack        : consumer has serviced channel y
//   y, valid   : granted index and its live flag (held until acked)
//   pending    : captured-request register
module pri_irq_ctrl
  import pri_irq_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] edge_sel,
  input  logic [N-1:0] mask,
  input  logic         mode,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] pending
);

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] req_q;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N-1:0] set, clr, eligible;
  logic [W-1:0] win_idx;
  logic         win_any;
  logic         accept;

  assign accept   = valid_q & ack;
  assign eligible = pending_q & mask;

  pri_rotate_enc #(
    .N (N),
    .W (W)
  ) u_enc (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .mode     (mode),
    .idx      (win_idx),
    .any      (win_any)
  );

  // Capture: set is OR-ed in after the clear so a coincident new event survives.
  always_comb begin
    set       = (edge_sel & req & ~req_q) | (~edge_sel & req);
    clr       = accept ? ({{(N-1){1'b0}}, 1'b1} << y_q) : '0;
    pending_d = (pending_q & ~clr) | set;
  end

  // Grant lock: a live grant only moves on ack, and then always through a bubble.
  always_comb begin
    y_d      = y_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    if (valid_q) begin
      if (ack) begin
        valid_d  = 1'b0;
        y_d      = '0;
        rr_ptr_d = y_q;
      end
    end else if (win_any) begin
      valid_d = 1'b1;
      y_d     = win_idx;
    end else begin
      y_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      req_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      pending_q <= pending_d;
      req_q     <= req;
      y_q       <= y_d;
      valid_q   <= valid_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign y       = y_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule
